// File: rtl/gmii_tx_framer_pkg.sv
// rtl/gmii_tx_framer_pkg.sv - shared state encodings, GMII framing bytes, CRC control codes and CRC32 step
package gmii_tx_framer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_ABORT,
    ST_DROP
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // {load_init, calc, d_valid}
  localparam logic [2:0] CRC_HOLD  = 3'b000;
  localparam logic [2:0] CRC_SHIFT = 3'b001;
  localparam logic [2:0] CRC_CALC  = 3'b011;
  localparam logic [2:0] CRC_INIT  = 3'b100;

  // Reflected IEEE 802.3 CRC32, one data byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_8023.sv
// rtl/crc32_8023.sv - byte-wide 802.3 CRC32 engine with registered, byte-serial FCS output
module crc32_8023
  import gmii_tx_framer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load_init,
  input  logic       i_calc,
  input  logic       i_d_valid,
  input  logic [7:0] i_d,
  output logic [7:0] o_crc
);

  logic [31:0] r_crc;
  logic [7:0]  r_out;

  // Hold presents FCS byte0; each shift presents the next byte and drops the one already sent.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_crc <= 32'hFFFF_FFFF;
      r_out <= 8'h00;
    end else if (i_load_init) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (i_calc && i_d_valid) begin
      r_crc <= crc32_byte(r_crc, i_d);
    end else if (i_d_valid) begin
      r_crc <= {8'hFF, r_crc[31:8]};
      r_out <= ~r_crc[15:8];
    end else begin
      r_out <= ~r_crc[7:0];
    end
  end

  assign o_crc = r_out;

endmodule

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII TX framer: preamble/SFD, data, optional pad, FCS, IFG, underrun abort
// Optional zero-padding of short frames is enabled by defining GMII_TX_PAD_EN.
module gmii_tx_framer
  import gmii_tx_framer_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int PRE_BYTES = 7,
  parameter int MIN_DATA  = 60
)
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic [7:0] o_gmii_txd,
  output logic       o_gmii_txen,
  output logic       o_gmii_txer,
  output logic       o_tx_busy,
  output logic       o_frame_done,
  output logic       o_frame_err
);

`ifdef GMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [15:0] PRE_LAST = 16'(PRE_BYTES - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_DATA);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [10:0] r_bytes;
  logic        r_tx_ready;
  logic [7:0]  r_txd;
  logic        r_txen, r_txer, r_fcs_sel, r_busy, r_done, r_err;

  logic [2:0]  w_crc_ctl;
  logic [7:0]  w_crc_d;
  logic [7:0]  w_crc_byte;
  logic [10:0] w_bytes_inc;
  logic        w_short;

  assign w_bytes_inc = (r_bytes == 11'h7FF) ? r_bytes : r_bytes + 11'd1;
  assign w_short     = (w_bytes_inc < MIN_LEN);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bytes    <= '0;
      r_tx_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_tx_valid) begin
          r_state <= ST_PRE;
          r_cnt   <= '0;
        end
        ST_PRE: if (r_cnt == PRE_LAST) r_state <= ST_SFD;
                else r_cnt <= r_cnt + 16'd1;
        ST_SFD: begin
          r_state    <= ST_DATA;
          r_tx_ready <= 1'b1;
          r_bytes    <= '0;
        end
        ST_DATA: if (!i_tx_valid) begin
          r_state    <= ST_ABORT;
          r_tx_ready <= 1'b0;
        end else begin
          r_bytes <= w_bytes_inc;
          if (i_tx_last) begin
            r_tx_ready <= 1'b0;
            r_cnt      <= '0;
            r_state    <= (PAD_EN && w_short) ? ST_PAD : ST_FCS;
          end
        end
        ST_PAD: begin
          r_bytes <= w_bytes_inc;
          if (!w_short) begin
            r_state <= ST_FCS;
            r_cnt   <= '0;
          end
        end
        ST_FCS: if (r_cnt == 16'd3) begin
          r_state <= ST_IFG;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 16'd1;
        // A frame waiting at the end of the gap starts its preamble without an IDLE cycle.
        ST_IFG: if (r_cnt == IFG_LAST) begin
          r_cnt   <= '0;
          r_state <= i_tx_valid ? ST_PRE : ST_IDLE;
        end else r_cnt <= r_cnt + 16'd1;
        ST_ABORT: begin
          r_state    <= ST_DROP;
          r_tx_ready <= 1'b1;
        end
        ST_DROP: if (i_tx_valid && i_tx_last) begin
          r_state    <= ST_IFG;
          r_cnt      <= '0;
          r_tx_ready <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_crc_ctl = CRC_HOLD;
    w_crc_d   = i_tx_data;
    case (r_state)
      ST_SFD:  w_crc_ctl = CRC_INIT;
      ST_DATA: w_crc_ctl = i_tx_valid ? CRC_CALC : CRC_HOLD;
      ST_PAD: begin
        w_crc_ctl = CRC_CALC;
        w_crc_d   = 8'h00;
      end
      ST_FCS:  w_crc_ctl = (r_cnt == 16'd0) ? CRC_HOLD : CRC_SHIFT;
      ST_IFG:  w_crc_ctl = (r_cnt == 16'd0) ? CRC_INIT : CRC_HOLD;
      default: w_crc_ctl = CRC_HOLD;
    endcase
  end

  crc32_8023 u_crc (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load_init (w_crc_ctl[2]),
    .i_calc      (w_crc_ctl[1]),
    .i_d_valid   (w_crc_ctl[0]),
    .i_d         (w_crc_d),
    .o_crc       (w_crc_byte)
  );

  // Output stage: every GMII byte appears one cycle after the FSM cycle that produced it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_txd     <= 8'h00;
      r_txen    <= 1'b0;
      r_txer    <= 1'b0;
      r_fcs_sel <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_txd     <= 8'h00;
      r_txen    <= 1'b0;
      r_txer    <= 1'b0;
      r_fcs_sel <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= (r_state != ST_IDLE);
      case (r_state)
        ST_PRE: begin
          r_txd  <= PREAMBLE_BYTE;
          r_txen <= 1'b1;
        end
        ST_SFD: begin
          r_txd  <= SFD_BYTE;
          r_txen <= 1'b1;
        end
        ST_DATA: if (i_tx_valid) begin
          r_txd  <= i_tx_data;
          r_txen <= 1'b1;
        end
        ST_PAD:  r_txen <= 1'b1;
        ST_FCS: begin
          r_txen    <= 1'b1;
          r_fcs_sel <= 1'b1;
          r_done    <= (r_cnt == 16'd3);
        end
        ST_ABORT: begin
          r_txen <= 1'b1;
          r_txer <= 1'b1;
          r_err  <= 1'b1;
        end
        default: r_txen <= 1'b0;
      endcase
    end
  end

  assign o_tx_ready   = r_tx_ready;
  assign o_gmii_txd   = r_fcs_sel ? w_crc_byte : r_txd;
  assign o_gmii_txen  = r_txen;
  assign o_gmii_txer  = r_txer;
  assign o_tx_busy    = r_busy;
  assign o_frame_done = r_done;
  assign o_frame_err  = r_err;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - directed self-checking bench for gmii_tx_framer
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       o_tx_ready, o_gmii_txen, o_gmii_txer, o_tx_busy, o_frame_done, o_frame_err;
  logic [7:0] o_gmii_txd;

  gmii_tx_framer #(.IFG_BYTES(12), .PRE_BYTES(7), .MIN_DATA(60)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .i_tx_last    (tx_last),
    .o_tx_ready   (o_tx_ready),
    .o_gmii_txd   (o_gmii_txd),
    .o_gmii_txen  (o_gmii_txen),
    .o_gmii_txer  (o_gmii_txer),
    .o_tx_busy    (o_tx_busy),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err)
  );

  always #4 clk = ~clk;

`ifdef GMII_TX_PAD_EN
  localparam int T2_LEN = 72;
`else
  localparam int T2_LEN = 13;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] pl[$];
  logic [7:0] exp_stream[$];
  int         exp_len[$];
  logic [7:0] seg[$];

  function automatic logic [31:0] crc_ref_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_expected();
    int n;
    int m;
    logic [31:0] c;
    logic [7:0]  b;
    n = pl.size();
    m = n;
`ifdef GMII_TX_PAD_EN
    if (m < 60) m = 60;
`endif
    c = 32'hFFFF_FFFF;
    repeat (7) exp_stream.push_back(8'h55);
    exp_stream.push_back(8'hD5);
    for (int i = 0; i < m; i++) begin
      b = (i < n) ? pl[i] : 8'h00;
      exp_stream.push_back(b);
      c = crc_ref_step(c, b);
    end
    c = ~c;
    exp_stream.push_back(c[7:0]);
    exp_stream.push_back(c[15:8]);
    exp_stream.push_back(c[23:16]);
    exp_stream.push_back(c[31:24]);
    exp_len.push_back(m + 12);
  endtask

  // Monitor state
  bit          mon_skip = 1'b0;
  bit          in_seg = 1'b0;
  int          gap = 0, last_gap = 0, done_n = 0, done_idx = -1;
  int          frames_checked = 0, last_len = 0;
  logic [31:0] last_fcs = 32'h0;
  int          n_txer = 0, n_err = 0, n_err_ok = 0, n_done_total = 0;

  task automatic end_segment();
    int n;
    int len;
    int nbad;
    logic [7:0] b;
    n = seg.size();
    nbad = 0;
    if (mon_skip) return;
    last_len = n;
    if (n >= 4) last_fcs = {seg[n-1], seg[n-2], seg[n-3], seg[n-4]};
    if (exp_len.size() == 0) begin
      check_eq("unexpected_frame_len", n, 0);
      return;
    end
    len = exp_len.pop_front();
    for (int i = 0; i < len; i++) begin
      b = exp_stream.pop_front();
      if (i >= n || seg[i] !== b) nbad++;
    end
    check_eq("frame_len", n, len);
    check_eq("frame_bytes_bad", nbad, 0);
    check_eq("frame_done_count", done_n, 1);
    check_eq("frame_done_pos", done_idx, len - 1);
    frames_checked++;
  endtask

  always @(negedge clk) begin
    n_txer       += int'(o_gmii_txer);
    n_err        += int'(o_frame_err);
    n_done_total += int'(o_frame_done);
    if (o_frame_err && o_gmii_txer && o_gmii_txen && o_gmii_txd == 8'h00) n_err_ok++;
    if (o_gmii_txen) begin
      if (!in_seg) begin
        in_seg   = 1'b1;
        last_gap = gap;
        seg.delete();
        done_n   = 0;
        done_idx = -1;
      end
      seg.push_back(o_gmii_txd);
      if (o_frame_done) begin
        done_n++;
        done_idx = seg.size() - 1;
      end
    end else if (in_seg) begin
      in_seg = 1'b0;
      gap    = 1;
      end_segment();
    end else begin
      gap++;
    end
  end

  bit drv_dead = 1'b0;

  task automatic drive_byte(input logic [7:0] b, input logic last);
    int k;
    tx_data  = b;
    tx_valid = 1'b1;
    tx_last  = last;
    k = 0;
    while (!drv_dead) begin
      @(negedge clk);
      if (o_tx_ready) break;
      k++;
      if (k > 200) begin
        check_eq("ready_timeout", 0, 1);
        drv_dead = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int underrun_at, input int hole);
    for (int i = 0; i < pl.size(); i++) begin
      if (i == underrun_at) begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat (hole) @(posedge clk);
        #1;
      end
      drive_byte(pl[i], i == pl.size() - 1);
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int k = 0; k < budget && frames_checked < target; k++) @(negedge clk);
    check_eq("frames_seen", frames_checked, target);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && o_tx_busy; k++) @(negedge clk);
    check_eq("busy_drops", o_tx_busy, 0);
  endtask

  int txer0, err0, errok0, done0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {o_gmii_txd, o_gmii_txen, o_gmii_txer, o_tx_ready,
                               o_tx_busy, o_frame_done, o_frame_err}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: "123456789", known FCS CBF43926, plus IDLE->preamble latency
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    push_expected();
    tx_data  = pl[0];
    tx_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("lat_idle", {o_gmii_txen, o_tx_ready, o_tx_busy}, 0);
    @(negedge clk);
    check_eq("lat_pre", {o_gmii_txd, o_gmii_txen, o_tx_busy, o_tx_ready}, {8'h55, 3'b110});
    send(-1, 0);
    wait_frames(1, 200);
`ifndef GMII_TX_PAD_EN
    check_eq("t1_fcs", last_fcs, 32'hCBF4_3926);
`endif

    // 2: one-byte frame
    pl.delete();
    pl.push_back(8'hAA);
    push_expected();
    send(-1, 0);
    wait_frames(2, 300);
    check_eq("t2_txen_cycles", last_len, T2_LEN);

    // 3: two 64-byte frames back to back
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i * 7 + 3));
    push_expected();
    send(-1, 0);
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(8'hF0 ^ 8'(i)));
    push_expected();
    send(-1, 0);
    wait_frames(4, 400);
    check_eq("t3_ifg_gap", last_gap, 12);

    // 4: underrun after 20 bytes, drained through tx_last, then a clean frame
    mon_skip = 1'b1;
    txer0 = n_txer; err0 = n_err; errok0 = n_err_ok;
    pl.delete();
    for (int i = 0; i < 40; i++) pl.push_back(8'(8'h10 + 8'(i)));
    send(20, 3);
    wait_idle();
    check_eq("t4_txer_bytes", n_txer - txer0, 1);
    check_eq("t4_frame_err", n_err - err0, 1);
    check_eq("t4_err_byte", n_err_ok - errok0, 1);
    mon_skip = 1'b0;
    pl.delete();
    for (int i = 0; i < 50; i++) pl.push_back(8'(8'hC3 + 8'(i * 5)));
    push_expected();
    send(-1, 0);
    wait_frames(5, 300);

    // 5: reset during FCS cnt1, then a clean frame
    mon_skip = 1'b1;
    done0 = n_done_total;
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(8'h5A ^ 8'(i * 3)));
    send(-1, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t5_reset_mid", {o_gmii_txen, o_tx_busy, o_frame_done, o_tx_ready}, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_skip = 1'b0;
    check_eq("t5_no_done", n_done_total - done0, 0);
    pl.delete();
    for (int i = 0; i < 45; i++) pl.push_back(8'(8'h81 + 8'(i * 11)));
    push_expected();
    send(-1, 0);
    wait_frames(6, 300);

    // 6: maximum-size 1514-byte frame
    pl.delete();
    for (int i = 0; i < 1514; i++) pl.push_back(8'($urandom_range(0, 255)));
    push_expected();
    send(-1, 0);
    wait_frames(7, 400);
    check_eq("t6_len", last_len, 1526);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
